counter_updown_mod: RTL and testbench
=====================================

Name: counter_updown_mod

Overview:
- Parametrised up/down counter with synchronous clear, parallel load, programmable modulus, wrap or saturate mode, terminal-count pulse and sticky overflow flag.
- Next generation of the team's fixed 4-bit up-counter.
- Used for sample/decimation counting, timeout generation and cascaded event counters in the servo firmware.
- `carry_out` is provided so instances can be chained.

Parameters:
- WIDTH, 16, counter width in bits (2..32).
- MODULUS, 0, count range; 0 means 2^WIDTH. Otherwise 2..2^WIDTH; the count runs 0..MODULUS-1.
- SATURATE, 0, boundary mode: 0 = wrap at boundary, 1 = hold at boundary.
- RESET_VALUE, 0, value of `out` after reset. Must be < MODULUS, or < 2^WIDTH when MODULUS = 0.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; forces `out` to 0.
- load  in  1  synchronous parallel load.
- load_value  in  WIDTH  value to load.
- enable  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- out  out  WIDTH  registered count.
- carry_out  out  1  combinational: enable & ~clear & ~load & at-boundary in the current direction.
- tc  out  1  registered terminal-count pulse.
- overflow  out  1  sticky flag: a boundary was crossed or hit.
- overflow_clear  in  1  synchronous clear of `overflow`.

Behaviour:
- Define TOP = MODULUS-1 when MODULUS≠0, else 2^WIDTH-1.
- Reset: `reset_n` low asynchronously forces out=RESET_VALUE, tc=0, overflow=0, independent of `clk`.
- Reset release: deasserts synchronously by the system; the first count edge is the first rising `clk` with `reset_n` high.
- Priority per rising edge: clear > load > enable.
  - clear=1: out←0, tc←0. `overflow` is unaffected by `clear`.
  - load=1 (clear=0): out←min(load_value, TOP). Not a boundary event: tc←0, overflow unchanged.
  - enable=1, up=1:
    - out<TOP: out←out+1.
    - out==TOP: boundary event; out←0 (SATURATE=0) or out←TOP (SATURATE=1).
  - enable=1, up=0:
    - out>0: out←out-1.
    - out==0: boundary event; out←TOP (SATURATE=0) or out←0 (SATURATE=1).
  - enable=0, no clear/load: out holds, tc←0.
- tc: high for exactly one cycle, in the cycle after a boundary event edge, i.e. concurrent with the wrapped or held value on `out`. Sustained enable at the boundary in saturate mode gives tc high every cycle.
- carry_out:
  - Combinational, zero latency: high when the next edge will be a boundary event.
  - Used as the `enable` of the next cascaded stage; that stage must share `up`.
- overflow:
  - Set on the edge of any boundary event.
  - Cleared by overflow_clear=1.
  - Boundary event and overflow_clear on the same edge: set wins (overflow=1).
- Direction change mid-count takes effect on the same edge; no extra latency.
- Arithmetic:
  - Unsigned, computed in WIDTH+1 bits internally.
  - No intermediate value outside 0..TOP ever appears on `out`.
  - When MODULUS=0 the wrap is natural binary rollover.
- `out` never exceeds TOP, including after load and after reset.
- X on control inputs while reset_n=0 has no effect.

Test Plan:
1. WIDTH=4, MODULUS=10, SATURATE=0, RESET_VALUE=0, enable=1, up=1 for 12 edges -> out 1..9, 0, 1, 2; tc=1 only in the cycle out=0; carry_out=1 only while out=9; overflow=1 after the wrap.
2. Same config, up=0 from out=0 -> out 9, 8, 7; tc=1 in the cycle out=9. Then overflow_clear pulse -> overflow=0. Then overflow_clear asserted coincident with the next 0→9 wrap -> overflow stays 1.
3. SATURATE=1, MODULUS=10, out=9, enable=1, up=1 for 3 edges -> out stays 9; tc=1 on each of the 3 cycles; then up=0 -> out 8.
4. load=1, load_value=13 with MODULUS=10 -> out=9. Then clear=1, load=1, enable=1 on the same edge -> out=0, overflow unchanged. Then load_value=5, load=1, enable=1 -> out=5.
5. WIDTH=8, MODULUS=0, RESET_VALUE=0x80, reset_n pulsed low between clock edges while counting -> out=0x80 immediately (before the next edge), tc=0, overflow=0; counting resumes 0x81 on the first edge after release.
6. Two cascaded WIDTH=4, MODULUS=10 instances, low stage's carry_out driving the high stage's enable, 105 enabled edges up -> high=0, low=5. Then down 6 edges -> high=9, low=9, both overflow flags set.

Source files
------------

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod.
// master drives clear/load/load_value/enable/up/overflow_clear; slave drives out/carry_out/tc/overflow.
interface counter_updown_mod_if #(
  parameter int unsigned WIDTH = 16
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             up;
  logic             overflow_clear;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             tc;
  logic             overflow;

  modport master (
    output clear, load, load_value,
    output enable, up, overflow_clear,
    input  out, carry_out, tc, overflow
  );

  modport slave (
    input  clear, load, load_value,
    input  enable, up, overflow_clear,
    output out, carry_out, tc, overflow
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down counter: modulus, wrap/saturate, tc pulse, sticky overflow, cascade carry.
// Ports: clk, reset_n (async low), bus (slave: controls in, out/carry_out/tc/overflow out).
module counter_updown_mod #(
  parameter int unsigned     WIDTH       = 16,
  parameter longint unsigned MODULUS     = 0,
  parameter bit              SATURATE    = 1'b0,
  parameter int unsigned     RESET_VALUE = 0
) (
  input logic                  clk,
  input logic                  reset_n,
  counter_updown_mod_if.slave  bus
);

  localparam logic [WIDTH:0] MAXV =
    {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] TOP =
    (MODULUS == 0) ? MAXV
                   : (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP_W = TOP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W =
    WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_zero, bnd;

  // Compare in WIDTH+1 bits so TOP = 2^WIDTH-1 and
  // a programmed modulus share one path.
  assign at_top  = ({1'b0, cnt_q} == TOP);
  assign at_zero = (cnt_q == '0);
  assign bnd     = bus.enable &
                   (bus.up ? at_top : at_zero);

  assign bus.carry_out = bnd & ~bus.clear & ~bus.load;
  assign bus.out       = cnt_q;
  assign bus.tc        = tc_q;
  assign bus.overflow  = ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q & ~bus.overflow_clear;
    if (bus.clear) begin
      cnt_d = '0;
    end else if (bus.load) begin
      cnt_d = ({1'b0, bus.load_value} > TOP)
              ? TOP_W : bus.load_value;
    end else if (bus.enable) begin
      if (bnd) begin
        // Boundary set beats a same-edge overflow_clear.
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (bus.up)
          cnt_d = SATURATE ? TOP_W : '0;
        else
          cnt_d = SATURATE ? '0 : TOP_W;
      end else if (bus.up) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= RST_W;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: wrap, saturate, load/clear, reset, cascade.
// Vector table for single-stage cases plus hand sequences for reset and chaining.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  counter_updown_mod_if #(.WIDTH(4)) ifa ();
  counter_updown_mod_if #(.WIDTH(4)) ifs ();
  counter_updown_mod_if #(.WIDTH(8)) ifb ();
  counter_updown_mod_if #(.WIDTH(4)) ifl ();
  counter_updown_mod_if #(.WIDTH(4)) ifh ();

  counter_updown_mod #(.WIDTH(4), .MODULUS(10))
    u_a (.clk(clk), .reset_n(rst_n), .bus(ifa));
  counter_updown_mod #(.WIDTH(4), .MODULUS(10),
                       .SATURATE(1'b1))
    u_s (.clk(clk), .reset_n(rst_n), .bus(ifs));
  counter_updown_mod #(.WIDTH(8), .MODULUS(0),
                       .RESET_VALUE(8'h80))
    u_b (.clk(clk), .reset_n(rst_b), .bus(ifb));
  counter_updown_mod #(.WIDTH(4), .MODULUS(10))
    u_l (.clk(clk), .reset_n(rst_n), .bus(ifl));
  counter_updown_mod #(.WIDTH(4), .MODULUS(10))
    u_h (.clk(clk), .reset_n(rst_n), .bus(ifh));

  assign ifh.enable         = ifl.carry_out;
  assign ifh.up             = ifl.up;
  assign ifh.overflow_clear = ifl.overflow_clear;
  assign ifh.clear          = 1'b0;
  assign ifh.load           = 1'b0;
  assign ifh.load_value     = '0;

  typedef struct {
    bit       sel;
    bit       clr, ld;
    logic [3:0] lv;
    bit       en, up, oc;
    bit       co;
    logic [3:0] out;
    bit       tc, ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    bit sel, bit clr, bit ld, logic [3:0] lv,
    bit en, bit up, bit oc,
    bit co, logic [3:0] o, bit tc, bit ov);
    vec_t v;
    v.sel = sel; v.clr = clr; v.ld = ld; v.lv = lv;
    v.en = en; v.up = up; v.oc = oc;
    v.co = co; v.out = o; v.tc = tc; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v, input bit on);
    ifa.clear          = on & v.clr;
    ifa.load           = on & v.ld;
    ifa.load_value     = v.lv;
    ifa.enable         = on & v.en;
    ifa.up             = v.up;
    ifa.overflow_clear = on & v.oc;
  endtask

  task automatic drive_s(input vec_t v, input bit on);
    ifs.clear          = on & v.clr;
    ifs.load           = on & v.ld;
    ifs.load_value     = v.lv;
    ifs.enable         = on & v.en;
    ifs.up             = v.up;
    ifs.overflow_clear = on & v.oc;
  endtask

  task automatic apply(input vec_t v, input int i);
    logic co, tc, ov;
    logic [3:0] o;
    @(negedge clk);
    drive_a(v, !v.sel);
    drive_s(v, v.sel);
    #1;
    co = v.sel ? ifs.carry_out : ifa.carry_out;
    chk("carry_out", i, 32'(co), 32'(v.co));
    @(posedge clk);
    #1;
    o  = v.sel ? ifs.out      : ifa.out;
    tc = v.sel ? ifs.tc       : ifa.tc;
    ov = v.sel ? ifs.overflow : ifa.overflow;
    chk("out", i, 32'(o), 32'(v.out));
    chk("tc", i, 32'(tc), 32'(v.tc));
    chk("overflow", i, 32'(ov), 32'(v.ov));
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0);
    // wrap mode, mod 10: count up through the wrap
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(0,0,0,0,1,1,0, 0,4'(k),0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0, 1,0,1,1));
    tbl.push_back(mk(0,0,0,0,1,1,0, 0,1,0,1));
    tbl.push_back(mk(0,0,0,0,1,1,0, 0,2,0,1));
    tbl.push_back(mk(0,1,0,0,1,1,0, 0,0,0,1));
    // count down from 0
    tbl.push_back(mk(0,0,0,0,1,0,0, 1,9,1,1));
    tbl.push_back(mk(0,0,0,0,1,0,0, 0,8,0,1));
    tbl.push_back(mk(0,0,0,0,1,0,0, 0,7,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,7,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1, 1,9,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,9,0,1));
    // load clamp and priority
    tbl.push_back(mk(0,0,1,13,0,1,0, 0,9,0,1));
    tbl.push_back(mk(0,0,1,13,1,1,0, 0,9,0,1));
    tbl.push_back(mk(0,1,1,13,1,1,0, 0,0,0,1));
    tbl.push_back(mk(0,0,1,5,1,1,0, 0,5,0,1));
    tbl.push_back(mk(0,0,0,0,1,1,0, 0,6,0,1));
    // saturate mode
    tbl.push_back(mk(1,0,1,9,0,1,0, 0,9,0,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,0,0,1,1,0, 1,9,1,1));
    tbl.push_back(mk(1,0,0,0,1,0,0, 0,8,0,1));
    tbl.push_back(mk(1,0,1,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(1,0,0,0,1,0,0, 1,0,1,1));

    drive_a(idle, 1'b0);
    drive_s(idle, 1'b0);
    ifa.enable = 1'bx;
    ifa.clear  = 1'bx;
    ifb.clear = 1'b0; ifb.load = 1'b0;
    ifb.load_value = '0; ifb.enable = 1'b0;
    ifb.up = 1'b1; ifb.overflow_clear = 1'b0;
    ifl.clear = 1'b0; ifl.load = 1'b0;
    ifl.load_value = '0; ifl.enable = 1'b0;
    ifl.up = 1'b1; ifl.overflow_clear = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_out_a", 0, 32'(ifa.out), 32'h0);
    chk("rst_tc_a", 0, 32'(ifa.tc), 32'h0);
    chk("rst_ov_a", 0, 32'(ifa.overflow), 32'h0);
    chk("rst_out_b", 0, 32'(ifb.out), 32'h80);
    @(negedge clk);
    drive_a(idle, 1'b0);
    rst_n = 1'b1;
    rst_b = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);
    @(negedge clk);
    drive_a(idle, 1'b0);
    drive_s(idle, 1'b0);

    // 8-bit natural rollover, then async reset pulse
    ifb.load = 1'b1; ifb.load_value = 8'hFF;
    @(posedge clk); #1;
    chk("b_load", 0, 32'(ifb.out), 32'hFF);
    @(negedge clk);
    ifb.load = 1'b0; ifb.enable = 1'b1;
    @(posedge clk); #1;
    chk("b_roll", 0, 32'(ifb.out), 32'h00);
    chk("b_tc", 0, 32'(ifb.tc), 32'h1);
    chk("b_ov", 0, 32'(ifb.overflow), 32'h1);
    #2 rst_b = 1'b0;
    #1;
    chk("b_rst_out", 0, 32'(ifb.out), 32'h80);
    chk("b_rst_tc", 0, 32'(ifb.tc), 32'h0);
    chk("b_rst_ov", 0, 32'(ifb.overflow), 32'h0);
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_resume", 0, 32'(ifb.out), 32'h81);
    chk("b_ov2", 0, 32'(ifb.overflow), 32'h0);
    @(negedge clk);
    ifb.enable = 1'b0;

    // cascade: 105 up, clear flags, 6 down
    ifl.enable = 1'b1; ifl.up = 1'b1;
    repeat (105) @(posedge clk);
    #1;
    chk("cas_lo", 0, 32'(ifl.out), 32'h5);
    chk("cas_hi", 0, 32'(ifh.out), 32'h0);
    chk("cas_ovl", 0, 32'(ifl.overflow), 32'h1);
    chk("cas_ovh", 0, 32'(ifh.overflow), 32'h1);
    @(negedge clk);
    ifl.enable = 1'b0; ifl.overflow_clear = 1'b1;
    @(posedge clk); #1;
    chk("cas_oclr_l", 0, 32'(ifl.overflow), 32'h0);
    chk("cas_oclr_h", 0, 32'(ifh.overflow), 32'h0);
    @(negedge clk);
    ifl.overflow_clear = 1'b0;
    ifl.enable = 1'b1; ifl.up = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("cas_co", 1, 32'(ifl.carry_out), 32'h1);
    @(posedge clk); #1;
    chk("cas_lo", 1, 32'(ifl.out), 32'h9);
    chk("cas_hi", 1, 32'(ifh.out), 32'h9);
    chk("cas_ovl", 1, 32'(ifl.overflow), 32'h1);
    chk("cas_ovh", 1, 32'(ifh.overflow), 32'h1);
    @(negedge clk);
    ifl.enable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
